// File: rtl/iter_seq_pkg.sv
// Shared definitions for the iterative sequencer: state encoding and
// default sizing of the iteration loop.
package iter_seq_pkg;

   // Default number of datapath iterations and index width
   localparam int ITERS_DEF = 8;
   localparam int CNT_W_DEF = 3;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/iter_counter.sv
// Iteration index counter: clear has priority over increment, and the
// terminal-count flag marks the last iteration (ITERS-1).
import iter_seq_pkg::*;

module iter_counter #(
   parameter int ITERS = ITERS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

   // Count register: clear wins so the index never wraps past LAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Terminal count decoded from the registered index
   always_comb begin
      tc = (cnt == LAST);
   end

endmodule

// File: rtl/iter_seq_ctrl.sv
// Iterative datapath sequencer: one LOAD cycle, ITERS RUN cycles, then a
// result held in DONE or ERR until the consumer accepts it.
//
// Handshakes: an operation is accepted on a rising edge where start=1 and
// ready=1; a result transfers on a rising edge where result_valid=1 and
// result_ready=1. result_valid never drops before that transfer unless
// abort or rst cancels the operation. abort has priority over every other
// input in the same cycle.
import iter_seq_pkg::*;

module iter_seq_ctrl #(
   parameter int ITERS = ITERS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             ready,
   output logic             dp_load,
   output logic             dp_en,
   output logic [CNT_W-1:0] dp_cnt,
   input  logic             dp_overflow,
   input  logic             dp_error,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             result_overflow,
   output logic             result_error,
   output logic             busy,
   output logic [2:0]       fsm_state
);

   logic [2:0]       state;
   logic [2:0]       next_state;
   logic             ovf_flag;
   logic             cnt_clear;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;

   // Next-state logic; abort overrides every other transition
   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_RUN;
            ST_RUN: begin
               if (dp_error)    next_state = ST_ERR;
               else if (cnt_tc) next_state = ST_DONE;
            end
            ST_DONE,
            ST_ERR:  if (result_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Sticky overflow: cleared in LOAD and whenever we head back to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_flag <= 1'b0;
      end else if (next_state == ST_IDLE || state == ST_LOAD) begin
         ovf_flag <= 1'b0;
      end else if (state == ST_RUN) begin
         ovf_flag <= ovf_flag | dp_overflow;
      end
   end

   // Counter runs only while in RUN and rests at 0 everywhere else
   always_comb begin
      cnt_inc   = (state == ST_RUN);
      cnt_clear = (state != ST_RUN) || abort || dp_error || cnt_tc;
   end

   iter_counter #(
      .ITERS (ITERS),
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .cnt   (cnt),
      .tc    (cnt_tc)
   );

   // Outputs decoded purely from registered state, counter and flag
   always_comb begin
      ready           = (state == ST_IDLE);
      busy            = (state == ST_LOAD) || (state == ST_RUN);
      dp_load         = (state == ST_LOAD);
      dp_en           = (state == ST_LOAD) || (state == ST_RUN);
      dp_cnt          = cnt;
      result_valid    = (state == ST_DONE) || (state == ST_ERR);
      result_error    = (state == ST_ERR);
      result_overflow = ovf_flag;
      fsm_state       = state;
   end

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Directed bench for iter_seq_ctrl with ITERS=8. Status bits are grouped as
// {ready,busy,dp_load,dp_en,result_valid,result_overflow,result_error}.
module tb_iter_seq_ctrl;

   localparam logic [6:0] F_IDLE     = 7'b1000000;
   localparam logic [6:0] F_LOAD     = 7'b0111000;
   localparam logic [6:0] F_RUN      = 7'b0101000;
   localparam logic [6:0] F_DONE     = 7'b0000100;
   localparam logic [6:0] F_DONE_OVF = 7'b0000110;
   localparam logic [6:0] F_ERR      = 7'b0000101;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       dp_overflow = 1'b0;
   logic       dp_error = 1'b0;
   logic       result_ready = 1'b0;
   logic       ready, dp_load, dp_en, result_valid, result_overflow, result_error, busy;
   logic [2:0] dp_cnt;
   logic [2:0] fsm_state;
   logic [6:0] flags;

   int n_vec = 0;
   int n_err = 0;

   iter_seq_ctrl #(.ITERS(8), .CNT_W(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .ready           (ready),
      .dp_load         (dp_load),
      .dp_en           (dp_en),
      .dp_cnt          (dp_cnt),
      .dp_overflow     (dp_overflow),
      .dp_error        (dp_error),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_overflow (result_overflow),
      .result_error    (result_error),
      .busy            (busy),
      .fsm_state       (fsm_state)
   );

   assign flags = {ready, busy, dp_load, dp_en, result_valid, result_overflow, result_error};

   // Clock
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle from IDLE; returns in cycle 1 (LOAD)
   task automatic start_op();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (flags !== F_IDLE || dp_cnt !== 3'd0) begin
         n_err++;
         $display("FAIL reset_async flags=%b cnt=%0d expected flags=%b cnt=0", flags, dp_cnt, F_IDLE);
      end
      step();
      rst = 1'b0;
      step();
      n_vec++;
      if (flags !== F_IDLE || fsm_state !== 3'd0) begin
         n_err++;
         $display("FAIL reset_release flags=%b state=%0d expected flags=%b state=0", flags, fsm_state, F_IDLE);
      end
   endtask

   task automatic test_nominal();
      start_op();
      n_vec++;
      if (flags !== F_LOAD || dp_cnt !== 3'd0) begin
         n_err++;
         $display("FAIL nominal_load flags=%b cnt=%0d expected flags=%b cnt=0", flags, dp_cnt, F_LOAD);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         n_vec++;
         if (flags !== F_RUN || dp_cnt !== 3'(k)) begin
            n_err++;
            $display("FAIL nominal_run k=%0d flags=%b cnt=%0d expected flags=%b cnt=%0d", k, flags, dp_cnt, F_RUN, k);
         end
      end
      step();
      n_vec++;
      if (flags !== F_DONE || dp_cnt !== 3'd0 || fsm_state !== 3'd3) begin
         n_err++;
         $display("FAIL nominal_done flags=%b cnt=%0d state=%0d expected flags=%b cnt=0 state=3", flags, dp_cnt, fsm_state, F_DONE);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL nominal_accept flags=%b expected %b", flags, F_IDLE);
      end
   endtask

   task automatic test_overflow_last();
      start_op();
      repeat (8) step();
      n_vec++;
      if (flags !== F_RUN || dp_cnt !== 3'd7) begin
         n_err++;
         $display("FAIL ovf_pre flags=%b cnt=%0d expected flags=%b cnt=7", flags, dp_cnt, F_RUN);
      end
      dp_overflow = 1'b1;
      step();
      dp_overflow = 1'b0;
      n_vec++;
      if (flags !== F_DONE_OVF) begin
         n_err++;
         $display("FAIL ovf_done flags=%b expected %b", flags, F_DONE_OVF);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL ovf_cleared flags=%b expected %b", flags, F_IDLE);
      end
   endtask

   task automatic test_error();
      start_op();
      repeat (4) step();
      n_vec++;
      if (dp_cnt !== 3'd3 || flags !== F_RUN) begin
         n_err++;
         $display("FAIL err_pre cnt=%0d flags=%b expected cnt=3 flags=%b", dp_cnt, flags, F_RUN);
      end
      dp_error = 1'b1;
      step();
      dp_error = 1'b0;
      n_vec++;
      if (flags !== F_ERR || dp_cnt !== 3'd0 || fsm_state !== 3'd4) begin
         n_err++;
         $display("FAIL err_state flags=%b cnt=%0d state=%0d expected flags=%b cnt=0 state=4", flags, dp_cnt, fsm_state, F_ERR);
      end
      step();
      n_vec++;
      if (flags !== F_ERR) begin
         n_err++;
         $display("FAIL err_hold flags=%b expected %b", flags, F_ERR);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL err_accept flags=%b expected %b", flags, F_IDLE);
      end
   endtask

   task automatic test_hold();
      start_op();
      repeat (9) step();
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (flags !== F_DONE) begin
            n_err++;
            $display("FAIL hold_done i=%0d flags=%b expected %b", i, flags, F_DONE);
         end
      end
      start = 1'b0;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL hold_accept flags=%b expected %b", flags, F_IDLE);
      end
      step();
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL hold_not_queued flags=%b expected %b", flags, F_IDLE);
      end
   endtask

   task automatic test_abort();
      start_op();
      repeat (5) step();
      n_vec++;
      if (dp_cnt !== 3'd4) begin
         n_err++;
         $display("FAIL abort_pre cnt=%0d expected 4", dp_cnt);
      end
      abort = 1'b1;
      dp_error = 1'b1;
      step();
      abort = 1'b0;
      dp_error = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (flags !== F_IDLE || dp_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL abort_idle i=%0d flags=%b cnt=%0d expected flags=%b cnt=0", i, flags, dp_cnt, F_IDLE);
         end
         step();
      end
      // abort during LOAD
      start_op();
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL abort_load flags=%b expected %b", flags, F_IDLE);
      end
      // abort beats start in IDLE
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL abort_vs_start flags=%b expected %b", flags, F_IDLE);
      end
      // abort beats result_ready in DONE but both lead to IDLE; also in DONE with start
      start_op();
      repeat (9) step();
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL abort_done flags=%b expected %b", flags, F_IDLE);
      end
   endtask

   task automatic test_back_to_back();
      start_op();
      repeat (9) step();
      result_ready = 1'b1;
      start = 1'b1;
      step();
      result_ready = 1'b0;
      n_vec++;
      if (flags !== F_IDLE) begin
         n_err++;
         $display("FAIL b2b_idle flags=%b expected %b", flags, F_IDLE);
      end
      step();
      start = 1'b0;
      n_vec++;
      if (flags !== F_LOAD) begin
         n_err++;
         $display("FAIL b2b_load flags=%b expected %b", flags, F_LOAD);
      end
      repeat (9) step();
      n_vec++;
      if (flags !== F_DONE) begin
         n_err++;
         $display("FAIL b2b_done flags=%b expected %b", flags, F_DONE);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_op();
      dp_overflow = 1'b1;
      repeat (6) step();
      dp_overflow = 1'b0;
      n_vec++;
      if (dp_cnt !== 3'd5 || result_overflow !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_pre cnt=%0d ovf=%b expected cnt=5 ovf=1", dp_cnt, result_overflow);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (flags !== F_IDLE || dp_cnt !== 3'd0) begin
         n_err++;
         $display("FAIL rstmid_async flags=%b cnt=%0d expected flags=%b cnt=0", flags, dp_cnt, F_IDLE);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if (flags !== F_IDLE) begin
            n_err++;
            $display("FAIL rstmid_no_result i=%0d flags=%b expected %b", i, flags, F_IDLE);
         end
      end
      start_op();
      repeat (8) step();
      n_vec++;
      if (flags !== F_RUN || dp_cnt !== 3'd7) begin
         n_err++;
         $display("FAIL rstmid_rerun flags=%b cnt=%0d expected flags=%b cnt=7", flags, dp_cnt, F_RUN);
      end
      step();
      n_vec++;
      if (flags !== F_DONE) begin
         n_err++;
         $display("FAIL rstmid_done flags=%b expected %b", flags, F_DONE);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_overflow_last();
      test_error();
      test_hold();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
